// File: rtl/simd_mac_lanes_if.sv
// Beat-level bus of simd_mac_lanes: upstream operands/controls and downstream results,
// each direction with its own valid/ready pair.
interface simd_mac_lanes_if #(
  parameter int LANES   = 2,
  parameter int A_WIDTH = 10,
  parameter int B_WIDTH = 9,
  parameter int Z_WIDTH = 19
);
  logic                       valid_i;
  logic                       ready_o;
  logic [LANES*A_WIDTH-1:0]   a_i;
  logic [LANES*B_WIDTH-1:0]   b_i;
  logic                       unsigned_a_i;
  logic                       unsigned_b_i;
  logic                       load_acc_i;
  logic                       subtract_i;
  logic                       valid_o;
  logic                       ready_i;
  logic [LANES*Z_WIDTH-1:0]   z_o;
  logic [LANES-1:0]           sat_o;

  modport master (
    output valid_i, a_i, b_i, unsigned_a_i, unsigned_b_i, load_acc_i, subtract_i, ready_i,
    input  ready_o, valid_o, z_o, sat_o
  );

  modport slave (
    input  valid_i, a_i, b_i, unsigned_a_i, unsigned_b_i, load_acc_i, subtract_i, ready_i,
    output ready_o, valid_o, z_o, sat_o
  );
endinterface

// File: rtl/simd_mac_lanes.sv
// Multi-lane multiply-accumulate: stage 1 captures operands/controls, stage 2 updates the
// per-lane accumulators and registers the shifted/rounded/saturated results.
module simd_mac_lanes #(
  parameter int LANES           = 2,
  parameter int A_WIDTH         = 10,
  parameter int B_WIDTH         = 9,
  parameter int ACC_WIDTH       = 32,
  parameter int Z_WIDTH         = 19,
  parameter int SHIFT_RIGHT     = 0,
  parameter int ROUND           = 0,
  parameter int SATURATE_ENABLE = 0
) (
  input logic             clock_i,
  input logic             reset_i,
  simd_mac_lanes_if.slave bus
);
  localparam int PW   = (A_WIDTH + B_WIDTH + 2 > ACC_WIDTH) ? (A_WIDTH + B_WIDTH + 2) : ACC_WIDTH;
  localparam int W    = ACC_WIDTH + 2;
  localparam int RBIT = (SHIFT_RIGHT > 0) ? (SHIFT_RIGHT - 1) : 0;

  // Clamp limits carry two guard bits so 2^Z_WIDTH-1 is representable even when Z_WIDTH==ACC_WIDTH.
  localparam logic signed [W-1:0] U_HI = (W'(1'b1) << Z_WIDTH) - W'(1'b1);
  localparam logic signed [W-1:0] U_LO = W'(1'b0);
  localparam logic signed [W-1:0] S_HI = (W'(1'b1) << (Z_WIDTH - 1)) - W'(1'b1);
  localparam logic signed [W-1:0] S_LO = W'(1'b0) - (W'(1'b1) << (Z_WIDTH - 1));

  function automatic logic [ACC_WIDTH-1:0] product(
    input logic [A_WIDTH-1:0] a,
    input logic [B_WIDTH-1:0] b,
    input logic               ua,
    input logic               ub
  );
    logic signed [A_WIDTH:0] ea;
    logic signed [B_WIDTH:0] eb;
    logic signed [PW-1:0]    p;
    ea = {(ua ? 1'b0 : a[A_WIDTH-1]), a};
    eb = {(ub ? 1'b0 : b[B_WIDTH-1]), b};
    p  = PW'(ea) * PW'(eb);
    return p[ACC_WIDTH-1:0];
  endfunction

  // Returns {sat, z} for one lane.
  function automatic logic [Z_WIDTH:0] shape(input logic [ACC_WIDTH-1:0] acc, input logic both_u);
    logic signed [W-1:0] v;
    logic signed [W-1:0] hi;
    logic signed [W-1:0] lo;
    logic [Z_WIDTH:0]    r;
    v = $signed({{2{acc[ACC_WIDTH-1]}}, acc}) >>> SHIFT_RIGHT;
    if (ROUND != 0 && SHIFT_RIGHT > 0) begin
      v = v + $signed(W'(acc[RBIT]));
    end else begin
      v = v;
    end
    hi = both_u ? U_HI : S_HI;
    lo = both_u ? U_LO : S_LO;
    if (SATURATE_ENABLE != 0 && v > hi) begin
      r = {1'b1, hi[Z_WIDTH-1:0]};
    end else if (SATURATE_ENABLE != 0 && v < lo) begin
      r = {1'b1, lo[Z_WIDTH-1:0]};
    end else begin
      r = {1'b0, v[Z_WIDTH-1:0]};
    end
    return r;
  endfunction

  logic                     en;
  logic                     s1_valid_q, s1_valid_d;
  logic [LANES*A_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [LANES*B_WIDTH-1:0] s1_b_q, s1_b_d;
  logic                     s1_ua_q, s1_ua_d;
  logic                     s1_ub_q, s1_ub_d;
  logic                     s1_load_q, s1_load_d;
  logic                     s1_sub_q, s1_sub_d;
  logic [ACC_WIDTH-1:0]     acc_q [LANES];
  logic [ACC_WIDTH-1:0]     acc_d [LANES];
  logic                     valid_q, valid_d;
  logic [LANES*Z_WIDTH-1:0] z_q, z_d;
  logic [LANES-1:0]         sat_q, sat_d;

  assign en          = !valid_q || bus.ready_i;
  assign bus.ready_o = en;
  assign bus.valid_o = valid_q;
  assign bus.z_o     = z_q;
  assign bus.sat_o   = sat_q;

  // Stage 1 capture of operands and beat controls.
  always_comb begin
    s1_valid_d = en ? bus.valid_i : s1_valid_q;
    if (en && bus.valid_i) begin
      s1_a_d    = bus.a_i;
      s1_b_d    = bus.b_i;
      s1_ua_d   = bus.unsigned_a_i;
      s1_ub_d   = bus.unsigned_b_i;
      s1_load_d = bus.load_acc_i;
      s1_sub_d  = bus.subtract_i;
    end else begin
      s1_a_d    = s1_a_q;
      s1_b_d    = s1_b_q;
      s1_ua_d   = s1_ua_q;
      s1_ub_d   = s1_ub_q;
      s1_load_d = s1_load_q;
      s1_sub_d  = s1_sub_q;
    end
  end

  // Stage 2: accumulator update and output shaping, only when a valid beat advances.
  always_comb begin
    valid_d = en ? s1_valid_q : valid_q;
    z_d     = z_q;
    sat_d   = sat_q;
    for (int k = 0; k < LANES; k++) begin
      acc_d[k] = acc_q[k];
    end
    if (en && s1_valid_q) begin
      for (int k = 0; k < LANES; k++) begin
        case ({s1_load_q, s1_sub_q})
          2'b10, 2'b11: acc_d[k] = product(s1_a_q[k*A_WIDTH +: A_WIDTH], s1_b_q[k*B_WIDTH +: B_WIDTH], s1_ua_q, s1_ub_q);
          2'b01:        acc_d[k] = acc_q[k] - product(s1_a_q[k*A_WIDTH +: A_WIDTH], s1_b_q[k*B_WIDTH +: B_WIDTH], s1_ua_q, s1_ub_q);
          default:      acc_d[k] = acc_q[k] + product(s1_a_q[k*A_WIDTH +: A_WIDTH], s1_b_q[k*B_WIDTH +: B_WIDTH], s1_ua_q, s1_ub_q);
        endcase
        {sat_d[k], z_d[k*Z_WIDTH +: Z_WIDTH]} = shape(acc_d[k], s1_ua_q & s1_ub_q);
      end
    end else begin
      z_d   = z_q;
      sat_d = sat_q;
    end
  end

  // State registers; reset discards in-flight beats and zeroes the accumulators.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_ua_q    <= 1'b0;
      s1_ub_q    <= 1'b0;
      s1_load_q  <= 1'b0;
      s1_sub_q   <= 1'b0;
      valid_q    <= 1'b0;
      z_q        <= '0;
      sat_q      <= '0;
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_ua_q    <= s1_ua_d;
      s1_ub_q    <= s1_ub_d;
      s1_load_q  <= s1_load_d;
      s1_sub_q   <= s1_sub_d;
      valid_q    <= valid_d;
      z_q        <= z_d;
      sat_q      <= sat_d;
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= acc_d[k];
      end
    end
  end
endmodule
